// File: rtl/vga_pixel_writer.sv
// rtl/vga_pixel_writer.sv - pixel set/clear/toggle/fill engine for the 160x120 monochrome framebuffer
// Read-modify-write on the byte holding a pixel, or a full-buffer fill stream, on the RAM write port.
module vga_pixel_writer (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Valid_i,
  output logic        Ready_o,
  input  logic [1:0]  Cmd_i,
  input  logic [7:0]  X_i,
  input  logic [6:0]  Y_i,
  output logic [11:0] Address_o,
  output logic [7:0]  DataToRAM_o,
  output logic        WriteEnable_o,
  input  logic [7:0]  DataFromRAM_i,
  output logic        Done_o,
  output logic        Error_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_WRITE,
    S_FILL,
    S_DONE
  } state_t;

  localparam logic [11:0] LAST_ADDR = 12'd2399;

  state_t      state, state_nx;
  logic [1:0]  cmd_q, cmd_nx;
  logic [2:0]  bit_q, bit_nx;
  logic        err_q, err_nx;
  logic [11:0] addr_nx;
  logic [7:0]  data_nx;
  logic        we_nx;
  logic        accept;
  logic [11:0] pix_addr;
  logic [7:0]  mask;
  logic [7:0]  modified;

  assign Ready_o = (state == S_IDLE) || (state == S_DONE);
  assign Done_o  = (state == S_DONE);
  assign Error_o = Done_o & err_q;
  assign accept  = Valid_i & Ready_o;

  // page*160 + X as page*128 + page*32 + X, matching the scan-out address generator
  assign pix_addr = {1'b0, Y_i[6:3], 7'b0} + {3'b0, Y_i[6:3], 5'b0} + {4'b0, X_i};
  assign mask     = 8'd1 << bit_q;

  always_comb begin
    modified = DataFromRAM_i ^ mask;
    case (cmd_q)
      2'b00:   modified = DataFromRAM_i | mask;
      2'b01:   modified = DataFromRAM_i & ~mask;
      default: modified = DataFromRAM_i ^ mask;
    endcase
  end

  always_comb begin
    state_nx = state;
    cmd_nx   = cmd_q;
    bit_nx   = bit_q;
    err_nx   = err_q;
    addr_nx  = Address_o;
    data_nx  = DataToRAM_o;
    we_nx    = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        state_nx = S_IDLE;
        if (accept) begin
          cmd_nx = Cmd_i;
          bit_nx = Y_i[2:0];
          err_nx = 1'b0;
          if (Cmd_i == 2'b11) begin
            state_nx = S_FILL;
            addr_nx  = 12'd0;
            data_nx  = X_i;
            we_nx    = 1'b1;
          end else if ((X_i > 8'd159) || (Y_i > 7'd119)) begin
            state_nx = S_DONE;
            err_nx   = 1'b1;
          end else begin
            state_nx = S_READ;
            addr_nx  = pix_addr;
          end
        end
      end
      S_READ: state_nx = S_WAIT;
      S_WAIT: begin
        data_nx  = modified;
        we_nx    = 1'b1;
        state_nx = S_WRITE;
      end
      S_WRITE: state_nx = S_DONE;
      S_FILL: begin
        if (Address_o == LAST_ADDR) begin
          state_nx = S_DONE;
        end else begin
          addr_nx = Address_o + 12'd1;
          we_nx   = 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state         <= S_IDLE;
      cmd_q         <= 2'b00;
      bit_q         <= 3'd0;
      err_q         <= 1'b0;
      Address_o     <= 12'd0;
      DataToRAM_o   <= 8'd0;
      WriteEnable_o <= 1'b0;
    end else begin
      state         <= state_nx;
      cmd_q         <= cmd_nx;
      bit_q         <= bit_nx;
      err_q         <= err_nx;
      Address_o     <= addr_nx;
      DataToRAM_o   <= data_nx;
      WriteEnable_o <= we_nx;
    end
  end

endmodule

// File: doc/vga_pixel_writer.md
# vga_pixel_writer

Write-side engine for the 160x120 monochrome framebuffer scanned out by the VGA controller. Accepts pixel commands (set, clear, toggle, fill) over a valid/ready handshake. Performs read-modify-write on the framebuffer byte that holds the addressed pixel, or streams a fill pattern over the whole buffer. Drives the write port of the dual-port framebuffer RAM; the VGA controller owns the other port, so no arbitration is needed.

## Interface
- No parameters.
- Clock  in  1  system clock, 25 MHz / 25.175 MHz, shared with the VGA controller.
- Reset  in  1  asynchronous, active-low.
- Valid_i  in  1  command present.
- Ready_o  out  1  engine idle; command accepted on a rising edge with Valid_i && Ready_o.
- Cmd_i  in  2  command: 00 set, 01 clear, 10 toggle, 11 fill.
- X_i  in  8  pixel column 0..159; for fill, the fill byte.
- Y_i  in  7  pixel row 0..119; ignored for fill.
- Address_o  out  12  RAM byte address, registered.
- DataToRAM_o  out  8  RAM write data, registered.
- WriteEnable_o  out  1  RAM write strobe, registered.
- DataFromRAM_i  in  8  RAM read data, one-cycle synchronous latency.
- Done_o  out  1  one-cycle pulse on command completion.
- Error_o  out  1  valid with Done_o; 1 = coordinates out of range, no write performed.

## Operation
- Memory map, identical to the scan-out side:
  - page = Y[6:3];
  - Address = page*160 + X, computed as page*128 + page*32 + X, 12-bit result;
  - bit = Y[2:0], LSB = top line of the page.
  - Valid range is 0..2399.
- States: IDLE, READ, WAIT, WRITE, FILL, DONE.
- IDLE: Ready_o=1. On accept, latch Cmd/X/Y.
  - Cmd 11: go to FILL, Address_o=0, DataToRAM_o=X_i, WriteEnable_o=1.
  - Otherwise, if X_i>159 or Y_i>119: go to DONE with the error flag set.
  - Otherwise: Address_o = computed address, go to READ.
- READ: RAM samples the address. Go to WAIT.
- WAIT: DataFromRAM_i is valid. Capture it and apply the mask m = 1<<bit:
  - set: d|m
  - clear: d&~m
  - toggle: d^m
  - Register the result to DataToRAM_o, set WriteEnable_o=1, go to WRITE.
- WRITE: RAM writes on this edge. WriteEnable_o←0, go to DONE.
- FILL: WriteEnable_o=1 for every address 0..2399 in order, one per cycle.
  - When Address_o==2399 is being written, the next edge sets WriteEnable_o←0 and goes to DONE.
  - Address_o holds 2399; it never reaches 2400.
- DONE: Done_o=1 for one cycle, Error_o=flag, Ready_o=1. A new command may be accepted in DONE (treated as IDLE).
- Valid_i and command inputs are ignored while Ready_o=0.
- Address_o and DataToRAM_o hold their last value when WriteEnable_o=0.

## Timing
- Reset values: Ready_o=1, Address_o=0, DataToRAM_o=0, WriteEnable_o=0, Done_o=0, Error_o=0, state IDLE.
- Reset mid-operation: WriteEnable_o drops immediately (async); the partial fill is abandoned and no Done_o is produced.
- Pixel command, accept at edge E0:
  - READ after E0;
  - WAIT after E0+1;
  - WriteEnable_o=1 for the cycle after E0+2;
  - Done_o=1 for the cycle after E0+3.
  - Next accept possible at E0+4, giving 4 cycles per pixel op.
- Out-of-range command: Done_o=1, Error_o=1 in the cycle after E0; WriteEnable_o never asserts.
- Fill, accept at E0: WriteEnable_o high for exactly 2400 cycles (after E0 through after E0+2399); Done_o in the cycle after E0+2400.
- Back-to-back ops on the same byte are coherent, because each write completes before the next read is issued.
- Error_o is 0 whenever Done_o is 0.

## Test plan
- RAM all 0x00; set (X=5, Y=10) → read at addr 165, write 0x04 to addr 165, Done_o at E0+3, Error_o=0.
- Follow with toggle (5, 10) → addr 165 becomes 0x00; then toggle (5, 11) → 0x08.
- RAM addr 2399=0xFF; clear (159, 119) → write 0x7F to addr 2399; no other address written.
- Set (160, 0) and set (0, 120) → no WriteEnable_o pulse; Done_o=1 and Error_o=1 one cycle after accept.
- Fill 0xAA → 2400 consecutive writes at addresses 0..2399 with data 0xAA, Done_o at E0+2400. Valid_i held high with a set command during the fill is not accepted until Ready_o returns.
- Assert Reset at fill address 1000 → WriteEnable_o=0 immediately; after release Ready_o=1, Address_o=0; a following set (0, 0) completes normally.
